// File: rtl/audio_sd_dac.sv
// Audio output stage: 2-entry sample FIFO, fixed-rate sample pacing, volume/mute
// scaling and a first-order sigma-delta modulator driving a 1-bit audio pin.
module audio_sd_dac #(
  parameter int SAMPLE_DIV = 1250
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] sample_in,
  input  logic       sample_valid,
  output logic       sample_ready,
  input  logic [1:0] volume,
  input  logic       mute,
  input  logic       clear_underrun,
  output logic       audio,
  output logic       sample_tick,
  output logic       underrun
);

  localparam int DIV_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SAMPLE_DIV - 1);

  logic [DIV_W-1:0] div_cnt_reg;
  logic [7:0]       fifo_mem_reg [2];
  logic             wr_ptr_reg;
  logic             rd_ptr_reg;
  logic [1:0]       count_reg;
  logic [1:0]       count_next;
  logic [7:0]       cur_sample_reg;
  logic [7:0]       eff_level_reg;
  logic [8:0]       acc_reg;
  logic [8:0]       acc_next;
  logic             audio_reg;
  logic             sample_tick_reg;
  logic             underrun_reg;

  logic             tick;
  logic             fifo_empty;
  logic             push;
  logic             pop;
  logic [7:0]       next_sample;
  logic signed [8:0] centred;
  logic signed [8:0] shifted [4];
  logic signed [8:0] scaled;
  logic [7:0]       level_calc;

  assign tick         = (div_cnt_reg == DIV_LAST);
  assign fifo_empty   = (count_reg == 2'd0);
  assign sample_ready = !rst && (count_reg != 2'd2);
  assign push         = sample_valid && sample_ready;
  assign pop          = tick && !fifo_empty;

  // An empty tick holds the previous sample, but still re-applies volume/mute.
  assign next_sample = pop ? fifo_mem_reg[rd_ptr_reg] : cur_sample_reg;
  assign centred     = $signed({1'b0, next_sample}) - 9'sd128;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_shift
      assign shifted[gi] = centred >>> gi;
    end
  endgenerate

  assign scaled     = shifted[volume];
  assign level_calc = mute ? 8'd128 : (scaled[7:0] + 8'd128);

  assign acc_next = {1'b0, acc_reg[7:0]} + {1'b0, eff_level_reg};

  always_comb begin
    count_next = count_reg;
    case ({push, pop})
      2'b10:   count_next = count_reg + 2'd1;
      2'b01:   count_next = count_reg - 2'd1;
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem_reg[wr_ptr_reg] <= sample_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt_reg     <= '0;
      wr_ptr_reg      <= 1'b0;
      rd_ptr_reg      <= 1'b0;
      count_reg       <= 2'd0;
      cur_sample_reg  <= 8'd128;
      eff_level_reg   <= 8'd128;
      acc_reg         <= 9'd0;
      audio_reg       <= 1'b0;
      sample_tick_reg <= 1'b0;
      underrun_reg    <= 1'b0;
    end else begin
      div_cnt_reg <= tick ? '0 : div_cnt_reg + DIV_W'(1);
      if (push) begin
        wr_ptr_reg <= ~wr_ptr_reg;
      end
      if (pop) begin
        rd_ptr_reg <= ~rd_ptr_reg;
      end
      count_reg <= count_next;
      if (tick) begin
        cur_sample_reg <= next_sample;
        eff_level_reg  <= level_calc;
      end
      // The carry out of the accumulator is the pulse-density bit.
      acc_reg         <= acc_next;
      audio_reg       <= acc_next[8];
      sample_tick_reg <= tick;
      if (tick && fifo_empty) begin
        underrun_reg <= 1'b1;
      end else if (clear_underrun) begin
        underrun_reg <= 1'b0;
      end
    end
  end

  assign audio       = audio_reg;
  assign sample_tick = sample_tick_reg;
  assign underrun    = underrun_reg;

endmodule

// File: tb/tb_audio_sd_dac.sv
// Bench for audio_sd_dac: a cycle model with a sample scoreboard queue checks the
// audio bitstream, tick timing and flags; 256-cycle windows check pulse density.
module tb_audio_sd_dac;

  localparam int DIV = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] sample_in = 8'd0;
  logic       sample_valid = 1'b0;
  logic       sample_ready;
  logic [1:0] volume = 2'd0;
  logic       mute = 1'b0;
  logic       clear_underrun = 1'b0;
  logic       audio;
  logic       sample_tick;
  logic       underrun;

  audio_sd_dac #(.SAMPLE_DIV(DIV)) dut (
    .clk(clk),
    .rst(rst),
    .sample_in(sample_in),
    .sample_valid(sample_valid),
    .sample_ready(sample_ready),
    .volume(volume),
    .mute(mute),
    .clear_underrun(clear_underrun),
    .audio(audio),
    .sample_tick(sample_tick),
    .underrun(underrun)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_mis = 0;

  // Model state; sb_q holds accepted samples awaiting their tick.
  logic [7:0] sb_q [$];
  int         m_div = 0;
  logic [7:0] m_cur = 8'd128;
  logic [7:0] m_eff = 8'd128;
  logic [8:0] m_acc = 9'd0;
  logic       m_audio = 1'b0;
  logic       m_tick = 1'b0;
  logic       m_under = 1'b0;
  int e_audio = 0, e_tick = 0, e_under = 0, e_ready = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Level by floor division of the centred sample, independent of shift tricks.
  function automatic int exp_level(input int samp, input int vol, input bit mu);
    int s;
    if (mu) return 128;
    s = samp - 128;
    if (s >= 0) s = s / (1 << vol);
    else        s = -((-s + (1 << vol) - 1) / (1 << vol));
    return s + 128;
  endfunction

  task automatic flush_errs();
    check_eq("audio_bits", e_audio, 0);
    check_eq("tick_timing", e_tick, 0);
    check_eq("underrun_flag", e_under, 0);
    check_eq("ready_flag", e_ready, 0);
    e_audio = 0; e_tick = 0; e_under = 0; e_ready = 0;
  endtask

  // One clock: advance the model with the inputs seen at this edge, then compare.
  task automatic cycle();
    logic       was_rst, push, tick, empty_tick, clr;
    logic [7:0] din;
    int         vol;
    bit         mu;
    was_rst = rst;
    push    = sample_valid && !rst && (sb_q.size() < 2);
    din     = sample_in;
    vol     = int'(volume);
    mu      = mute;
    clr     = clear_underrun;
    @(posedge clk);
    #1;
    if (was_rst) begin
      sb_q.delete();
      m_div = 0; m_cur = 8'd128; m_eff = 8'd128; m_acc = 9'd0;
      m_audio = 1'b0; m_tick = 1'b0; m_under = 1'b0;
    end else begin
      m_acc      = {1'b0, m_acc[7:0]} + {1'b0, m_eff};
      m_audio    = m_acc[8];
      tick       = (m_div == DIV - 1);
      empty_tick = tick && (sb_q.size() == 0);
      m_tick     = tick;
      if (tick) begin
        if (!empty_tick) m_cur = sb_q.pop_front();
        m_eff = 8'(exp_level(int'(m_cur), vol, mu));
      end
      if (empty_tick)  m_under = 1'b1;
      else if (clr)    m_under = 1'b0;
      if (push) sb_q.push_back(din);
      m_div = tick ? 0 : m_div + 1;
    end
    if (audio !== m_audio)           e_audio++;
    if (sample_tick !== m_tick)      e_tick++;
    if (underrun !== m_under)        e_under++;
    if (sample_ready !== (!rst && (sb_q.size() < 2))) e_ready++;
    if (m_tick) begin
      $display("tick @%0t level=%0d underrun=%0b fifo=%0d", $time, m_eff, m_under, sb_q.size());
      flush_errs();
    end
  endtask

  task automatic wait_div(input int d);
    for (int i = 0; i < 2 * DIV && m_div != d; i++) cycle();
  endtask

  task automatic count_ones(input string tag, input int exp_ones);
    int ones;
    ones = 0;
    for (int i = 0; i < 256; i++) begin
      cycle();
      ones += int'(audio);
    end
    check_eq(tag, ones, exp_ones);
  endtask

  task automatic density(input string tag, input logic [7:0] v, input logic [1:0] vol,
                         input logic mu, input int exp_ones);
    sample_in = v; sample_valid = 1'b1; volume = vol; mute = mu;
    repeat (64) cycle();
    count_ones(tag, exp_ones);
  endtask

  initial begin
    // Reset and idle
    repeat (3) cycle();
    rst = 1'b0;
    #1;
    check_eq("rst_audio", audio, 0);
    check_eq("rst_underrun", underrun, 0);
    check_eq("rst_ready", sample_ready, 1);
    repeat (DIV) cycle();
    check_eq("first_tick", sample_tick, 1);
    check_eq("first_underrun", underrun, 1);
    count_ones("idle_density", 128);

    // Density at full volume
    density("dens_c0", 8'hC0, 2'd0, 1'b0, 192);
    density("dens_00", 8'h00, 2'd0, 1'b0, 0);
    density("dens_ff", 8'hFF, 2'd0, 1'b0, 255);

    // Volume and mute
    density("vol2_ff", 8'hFF, 2'd2, 1'b0, 159);
    density("vol2_00", 8'h00, 2'd2, 1'b0, 96);
    density("vol3_80", 8'h80, 2'd3, 1'b0, 128);
    density("mute_ff", 8'hFF, 2'd0, 1'b1, 128);
    mute = 1'b0;
    wait_div(5);
    volume = 2'd1;
    repeat (40) cycle();
    volume = 2'd0;

    // Backpressure
    sample_valid = 1'b0;
    repeat (3 * DIV) cycle();
    wait_div(2);
    sample_in = 8'h10; sample_valid = 1'b1;
    cycle();
    sample_in = 8'h20;
    cycle();
    sample_in = 8'h30;
    #1;
    check_eq("bp_ready_low", sample_ready, 0);
    wait_div(0);
    check_eq("bp_ready_after_tick", sample_ready, 1);
    cycle();
    sample_valid = 1'b0;
    check_eq("bp_ready_full_again", sample_ready, 0);
    repeat (3 * DIV) cycle();

    // Underrun handling
    wait_div(5);
    clear_underrun = 1'b1; cycle(); clear_underrun = 1'b0;
    check_eq("ur_clear", underrun, 0);
    wait_div(DIV - 1); cycle();
    check_eq("ur_set_empty", underrun, 1);
    wait_div(DIV - 1);
    clear_underrun = 1'b1; cycle(); clear_underrun = 1'b0;
    check_eq("ur_set_wins", underrun, 1);
    wait_div(6);
    clear_underrun = 1'b1; cycle(); clear_underrun = 1'b0;
    check_eq("ur_clear_later", underrun, 0);
    wait_div(DIV - 1);
    sample_in = 8'h40; sample_valid = 1'b1; cycle(); sample_valid = 1'b0;
    check_eq("ur_push_at_tick", underrun, 1);
    check_eq("ur_push_ready", sample_ready, 1);
    wait_div(5);
    clear_underrun = 1'b1; cycle(); clear_underrun = 1'b0;
    wait_div(DIV - 1); cycle();
    check_eq("ur_sample_popped", underrun, 0);
    repeat (2 * DIV) cycle();

    // Reset mid-stream with a full FIFO
    wait_div(1);
    sample_in = 8'hE0; sample_valid = 1'b1; cycle();
    sample_in = 8'hF0; cycle();
    sample_valid = 1'b0;
    wait_div(8);
    rst = 1'b1;
    cycle(); cycle();
    rst = 1'b0;
    #1;
    check_eq("mid_rst_tick", sample_tick, 0);
    check_eq("mid_rst_audio", audio, 0);
    check_eq("mid_rst_underrun", underrun, 0);
    check_eq("mid_rst_ready", sample_ready, 1);
    density("post_rst_60", 8'h60, 2'd0, 1'b0, 96);
    sample_valid = 1'b0;
    repeat (4) cycle();
    flush_errs();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/audio_sd_dac.md
# audio_sd_dac

Sample-rate audio output stage feeding the `uio_out[7]` audio pin. Accepts 8-bit unsigned PCM samples over a valid/ready handshake into a 2-entry FIFO and paces them out at a fixed sample rate. Applies volume scaling and mute, then converts each sample to a 1-bit pulse-density stream with a first-order sigma-delta modulator. Sits directly downstream of the tone/sample generator and drives the audio pin as the last stage.

## Interface
- SAMPLE_DIV, 1250, clock cycles per output sample (≥4); 1250 at 25 MHz gives 20 kHz.
- clk  input  1  system clock; all logic on its rising edge.
- rst  input  1  synchronous, active-high reset.
- sample_in  input  8  unsigned PCM sample; 128 = midscale.
- sample_valid  input  1  sample_in holds a sample to transfer.
- sample_ready  output  1  block can accept a sample this cycle.
- volume  input  2  attenuation: arithmetic right shift 0..3 of the centred sample.
- mute  input  1  forces midscale level.
- clear_underrun  input  1  clears the underrun flag.
- audio  output  1  registered sigma-delta bitstream.
- sample_tick  output  1  one-cycle pulse when a new level takes effect.
- underrun  output  1  sticky; a tick found the FIFO empty.

## Operation
- **Divider.** `div_cnt` counts 0..SAMPLE_DIV-1 and wraps. A tick occurs in the cycle where div_cnt == SAMPLE_DIV-1.
- **FIFO.** 2 entries; occupancy `count` is 0..2.
  - sample_ready = !rst && count < 2 (combinational).
  - Push when sample_valid && sample_ready. Order is first-in, first-out.
- **Tick, FIFO non-empty:** pop the head into `cur_sample`.
- **Tick, FIFO empty:** hold `cur_sample` and set `underrun`. There is no bypass: a push in the same cycle as an empty-FIFO tick lands in the FIFO (count becomes 1) and is not popped.
- **Push and pop in the same cycle:** count is unchanged.
- **Level.** At every tick, compute `eff_level` from the popped or held sample plus the current volume and mute:
  - s = {1'b0,sample} − 128, a 9-bit signed value.
  - scaled = s >>> volume.
  - eff_level = scaled + 128, truncated to 8 bits. The result always lies in 0..255.
  - mute = 1 gives eff_level = 128.
  - volume and mute are sampled only at a tick.
- **Modulator,** every cycle: acc ← {1'b0, acc[7:0]} + eff_level (9-bit); audio ← carry, i.e. the new acc[8].
  - For a constant eff_level L, any 256 consecutive audio bits contain exactly L ones.
- **underrun.** Set on an empty tick; cleared by clear_underrun. If both happen in the same cycle, set wins.
- **Reset** (rst high at an edge): div_cnt=0, count=0, cur_sample=128, eff_level=128, acc=0, audio=0, sample_tick=0, underrun=0.
  - While rst is high, sample_ready=0 and pushes are ignored.
  - Reset mid-stream discards FIFO contents.

## Timing
- After reset is released, the first tick is at cycle SAMPLE_DIV-1, counting the first non-reset cycle as 0. Ticks then repeat every SAMPLE_DIV cycles.
- **Tick at cycle T:**
  - cur_sample, eff_level and underrun update at the end of T.
  - sample_tick = 1 during T+1 only.
  - audio first reflects the new level in T+2.
- **FIFO flags:**
  - A push at cycle T is visible in count, and therefore in sample_ready, from T+1.
  - A pop at a tick frees a slot from T+1.
- **Latency:** a sample pushed into an empty FIFO at cycle T is output at the first tick after T. Its effect appears on audio 2 cycles after that tick.
- **Registered outputs:** audio, sample_tick and underrun are registered. sample_ready is the only combinational output.

## Test plan
The bench uses SAMPLE_DIV = 16.

1. **Reset.** Assert rst for 3 cycles, then release; hold sample_valid = 0.
   - In the first non-reset cycle: audio = 0, underrun = 0, sample_ready = 1.
   - The first tick (cycle 15) sets underrun = 1.
   - Audio has 128 ones in any 256-cycle window.
2. **Density.** Push 0xC0 at volume 0, then refill before every tick. After the tick, any 256-cycle window holds exactly 192 ones.
   - 0x00 gives all zeros; 0xFF gives 255 ones per 256.
3. **Volume and mute.**
   - volume = 2 with 0xFF gives L = 159; with 0x00 gives L = 96.
   - volume = 3 with 0x80 gives L = 128.
   - mute = 1 with 0xFF gives 128.
   - Changing volume mid-period has no effect until the next tick.
4. **Backpressure.** Push 0x10 and 0x20 back-to-back; sample_ready drops in the next cycle.
   - Hold 0x30 valid: it is accepted the cycle after the tick.
   - Levels output at successive ticks are 0x10, 0x20, 0x30.
5. **Underrun.**
   - Empty FIFO at a tick: underrun = 1, and the previous level is held.
   - Pulse clear_underrun in the same cycle as a second empty tick: underrun stays 1.
   - Clear in a later, non-tick cycle: underrun becomes 0.
   - sample_valid = 1 exactly at an empty tick: underrun is set, and the sample is output at the following tick.
6. **Reset mid-stream.** Assert rst with count = 2 partway through a period.
   - Afterwards: count = 0, div_cnt = 0, level 128, sample_tick = 0.
   - The old FIFO samples never appear.
